keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 125 ++++++++++++
 tb/tb_keypad_scanner.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scan, debounce and ASCII key events.
// Optional held-key auto-repeat is compiled in when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 25,
  parameter int REPEAT_RATE    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       btn_valid,
  output logic [7:0] btn_char,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
  // Key index k = row*4 + col, character k in byte k.
  localparam logic [127:0] KEY_MAP = {"=", 8'h08, "0", "C", "*", "9", "8", "7",
                                      "-", "6", "5", "4", "+", "3", "2", "1"};
  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;
  state_t state;
  logic [3:0] row_s1, row_s2;
  logic [DW-1:0] dwell;
  logic [1:0] col;
  logic [15:0] snap;
  logic scan_done;
  logic [3:0] cand, cnt, idx;
  logic [4:0] n_set;
  logic is_key, is_none, hit, accept, rep_fire, fire;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
      dwell <= '0;
      col <= '0;
      col_out <= 4'b1110;
      snap <= '0;
      scan_done <= 1'b0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      scan_done <= dwell == LAST && col == 2'd3;
      if (dwell == LAST) begin
        dwell <= '0;
        col <= col + 2'd1;
        col_out <= {col_out[2:0], col_out[3]};
        snap[{col, 2'b00} +: 4] <= ~row_s2;
      end else dwell <= dwell + 1'b1;
    end
  // Snapshot bit b = col*4 + row; key index swaps the two halves.
  always_comb begin
    n_set = '0;
    idx = '0;
    for (int b = 0; b < 16; b++)
      if (snap[b]) begin
        n_set = n_set + 5'd1;
        idx = {2'(b), 2'(b >> 2)};
      end
  end
  assign is_key = n_set == 5'd1;
  assign is_none = n_set == 5'd0;
  assign hit = is_key && idx == cand;
  assign accept = scan_done && is_key &&
                  (state == S_IDLE ? DEBOUNCE_SCANS == 1 :
                   state == S_DEBOUNCE && idx == cand && cnt + 4'd1 == DEB);
`ifdef KEYPAD_REPEAT_EN
  logic [7:0] rep;
  logic first;
  assign rep_fire = scan_done && state == S_PRESSED && hit &&
                    rep + 8'd1 == (first ? 8'(REPEAT_DELAY) : 8'(REPEAT_RATE));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rep <= '0;
      first <= 1'b1;
    end else if (scan_done) begin
      rep <= state == S_PRESSED && hit && !rep_fire ? rep + 8'd1 : 8'd0;
      first <= state == S_PRESSED && hit ? first && !rep_fire : 1'b1;
    end
`else
  assign rep_fire = 1'b0;
`endif
  assign fire = accept || rep_fire;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cand <= '0;
      cnt <= '0;
      btn_valid <= 1'b0;
      btn_char <= 8'h00;
      key_held <= 1'b0;
    end else begin
      btn_valid <= fire;
      if (fire) btn_char <= KEY_MAP[{idx, 3'b000} +: 8];
      if (accept) key_held <= 1'b1;
      if (scan_done)
        case (state)
          S_IDLE:
            if (is_key) begin
              cand <= idx;
              cnt <= 4'd1;
              state <= accept ? S_PRESSED : S_DEBOUNCE;
            end
          S_DEBOUNCE: begin
            cand <= idx;
            cnt <= hit ? cnt + 4'd1 : 4'd1;
            state <= !is_key ? S_IDLE : accept ? S_PRESSED : S_DEBOUNCE;
          end
          S_PRESSED:
            if (is_none) begin
              cnt <= 4'd1;
              state <= DEBOUNCE_SCANS == 1 ? S_IDLE : S_RELEASE;
              if (DEBOUNCE_SCANS == 1) key_held <= 1'b0;
            end
          S_RELEASE: begin
            cnt <= cnt + 4'd1;
            state <= !is_none ? S_PRESSED : cnt + 4'd1 == DEB ? S_IDLE : S_RELEASE;
            if (is_none && cnt + 4'd1 == DEB) key_held <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad bench against a scan-level reference model.
module tb_keypad_scanner;
  localparam int SD = 4, DEB = 2, RDLY = 3, RRATE = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] row_in, col_out;
  logic btn_valid, key_held;
  logic [7:0] btn_char;
  logic [15:0] pressed = '0;
  int checks = 0, errors = 0;
  int hist[$];
  int cand, run, prev;
  bit held, pend;
  logic [7:0] exp_char;
  byte km[16] = '{"1", "2", "3", "+", "4", "5", "6", "-",
                  "7", "8", "9", "*", "C", "0", 8'h08, "="};
  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .btn_valid(btn_valid), .btn_char(btn_char), .key_held(key_held)
  );
  always #5 clk = ~clk;
  // A pressed key connects its row to its column; only the driven column pulls low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] key_bit(input int k);
    return 16'(1) << k;
  endfunction
  function automatic int decode(input logic [15:0] m);
    int n = 0, k = -1;
    for (int i = 0; i < 16; i++) if (m[i]) begin n++; k = i; end
    return n == 0 ? -1 : n > 1 ? -2 : k;
  endfunction
  function automatic bit last_all(input int code);
    if (hist.size() != DEB) return 0;
    foreach (hist[i]) if (hist[i] != code) return 0;
    return 1;
  endfunction
  task automatic model_scan(input logic [15:0] m);
    int code = decode(m);
    pend = 0;
    hist.push_back(code);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (!held) begin
      if (code >= 0 && last_all(code)) begin
        pend = 1; held = 1; cand = code; run = 0; exp_char = 8'(km[code]);
      end
    end else if (last_all(-1)) held = 0;
    else begin
`ifdef KEYPAD_REPEAT_EN
      if (prev != -1 && code == cand) begin
        run++;
        if (run == RDLY || (run > RDLY && (run - RDLY) % RRATE == 0)) pend = 1;
      end else run = 0;
`endif
    end
    prev = code;
  endtask
  task automatic run_scan(input logic [15:0] m, input int ncyc);
    logic [3:0] exp_col;
    pressed = m;
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk);
      #1;
      exp_col = 4'hF ^ (4'h1 << (((j + 1) / 4) % 4));
      check("col_out", 32'(col_out), 32'(exp_col));
      check("btn_valid", 32'(btn_valid), j == 0 ? 32'(pend) : 32'd0);
      check("key_held", 32'(key_held), 32'(held));
      check("btn_char", 32'(btn_char), 32'(exp_char));
    end
    if (ncyc == 16) model_scan(m);
  endtask
  task automatic run_scans(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_scan(m, 16);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_col_out", 32'(col_out), 32'h0E);
    check("rst_btn_valid", 32'(btn_valid), 32'd0);
    check("rst_btn_char", 32'(btn_char), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    hist.delete();
    held = 0; pend = 0; exp_char = 8'h00; run = 0; prev = -3; cand = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    int t, len, a, b;
    logic [15:0] m;
    do_reset();
    run_scans(key_bit(6), 10);
    run_scans('0, 4);
    run_scans(key_bit(13), 1);
    run_scans('0, 1);
    run_scans(key_bit(13), 4);
    run_scans('0, 3);
    run_scans(key_bit(3), 1);
    run_scans(key_bit(11), 3);
    run_scans('0, 3);
    run_scans(key_bit(0) | key_bit(1), 4);
    run_scans('0, 3);
    run_scans(key_bit(15), 3);
    run_scans(key_bit(15) | key_bit(12), 3);
    run_scans('0, 3);
    run_scans(key_bit(14), 10);
    run_scans('0, 3);
    run_scans(key_bit(5), 4);
    run_scan(key_bit(5), 7);
    do_reset();
    run_scans(key_bit(5), 4);
    run_scans('0, 3);
    for (int s = 0; s < 100; s++) begin
      t = $urandom_range(0, 5);
      len = $urandom_range(1, 6);
      a = $urandom_range(0, 15);
      b = (a + 1 + $urandom_range(0, 14)) % 16;
      if (t < 2) m = '0;
      else if (t < 4) m = key_bit(a);
      else if (t == 4) m = key_bit(a) | key_bit(b);
      else begin
        run_scans(key_bit(a), len);
        m = key_bit(a) | key_bit(b);
      end
      run_scans(m, len);
    end
    run_scans('0, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
